// File: rtl/dynamatic_pkg.sv
// Shared elaboration helpers for the handshake component library.
// Only width derivation lives here; components keep their own constants.
package dynamatic_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Index registers never collapse to zero bits, even for a one-entry table.
    function automatic int index_width(input int depth);
        return (depth <= 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/handshake_oehb_slot.sv
// One-slot output elastic buffer: registers valid and data, and passes
// ready through so the slot can refill in the same cycle it drains.
module handshake_oehb_slot #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ins,
    input  logic             ins_valid,
    output logic             ins_ready,
    output logic [WIDTH-1:0] outs,
    output logic             outs_valid,
    input  logic             outs_ready
);

    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             accept;

    always_comb begin
        ins_ready = !full_q || outs_ready;
        accept    = ins_valid && ins_ready;
        full_d    = full_q;
        data_d    = data_q;
        if (accept) begin
            full_d = 1'b1;
            data_d = ins;
        end else if (outs_ready) begin
            // Stale data is left in place; it is invisible while empty.
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign outs       = data_q;
    assign outs_valid = full_q;

endmodule

// File: rtl/handshake_constant_seq.sv
// Token-triggered constant sequencer: each accepted control token emits the
// next entry of a compile-time table through a registered output slot.
module handshake_constant_seq
    import dynamatic_pkg::*;
#(
    parameter int                          DATA_WIDTH = 32,
    parameter int                          DEPTH      = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0] VALUES     = '0,
    parameter int                          MODE       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  outs_last
);

    localparam int            IW       = index_width(DEPTH);
    localparam int            TBL      = 1 << IW;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    if (DEPTH < 1 || DEPTH > 256) begin : g_bad_depth
        $error("handshake_constant_seq: DEPTH must be in 1..256");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("handshake_constant_seq: MODE must be 0 or 1");
    end
    if ($bits(VALUES) != DEPTH * DATA_WIDTH) begin : g_bad_values
        $error("handshake_constant_seq: VALUES width must be DEPTH*DATA_WIDTH");
    end

    // Table padded to a power of two so the index mux never reads out of range.
    logic [DATA_WIDTH-1:0] table_w [TBL];

    for (genvar gi = 0; gi < TBL; gi++) begin : g_tbl
        if (gi < DEPTH) begin : g_entry
            assign table_w[gi] = VALUES[gi*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign table_w[gi] = '0;
        end
    end

    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       idx_d;
    logic                at_last;
    logic                slot_ready;
    logic                accept;
    logic [DATA_WIDTH:0] slot_in;
    logic [DATA_WIDTH:0] slot_out;

    always_comb begin
        at_last = (idx_q == LAST_IDX);
        accept  = ctrl_valid && slot_ready;
        slot_in = {at_last, table_w[idx_q]};
        idx_d   = idx_q;
        if (accept) begin
            if (at_last) begin
                idx_d = (MODE == 1) ? idx_q : '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    handshake_oehb_slot #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .ins       (slot_in),
        .ins_valid (ctrl_valid),
        .ins_ready (slot_ready),
        .outs      (slot_out),
        .outs_valid(outs_valid),
        .outs_ready(outs_ready)
    );

    assign ctrl_ready = slot_ready;
    assign outs       = slot_out[DATA_WIDTH-1:0];
    assign outs_last  = slot_out[DATA_WIDTH];

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Bench for handshake_constant_seq: four instances (cyclic, saturate, DEPTH=1,
// DEPTH=3) share one handshake stimulus and are checked against a token model.
module tb_handshake_constant_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ctrl_valid = 1'b0;
    logic outs_ready = 1'b0;

    logic [4:0] outs_w       [4];
    logic       outs_valid_w [4];
    logic       outs_last_w  [4];
    logic       ctrl_ready_w [4];

    always #5 clk = ~clk;

    handshake_constant_seq #(.DATA_WIDTH(5), .DEPTH(4), .VALUES({5'd3, 5'd9, 5'd1, 5'd14}), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready_w[0]),
        .outs(outs_w[0]), .outs_valid(outs_valid_w[0]), .outs_ready(outs_ready), .outs_last(outs_last_w[0]));
    handshake_constant_seq #(.DATA_WIDTH(5), .DEPTH(4), .VALUES({5'd3, 5'd9, 5'd1, 5'd14}), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready_w[1]),
        .outs(outs_w[1]), .outs_valid(outs_valid_w[1]), .outs_ready(outs_ready), .outs_last(outs_last_w[1]));
    handshake_constant_seq #(.DATA_WIDTH(5), .DEPTH(1), .VALUES(5'b01110), .MODE(0)) dut2 (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready_w[2]),
        .outs(outs_w[2]), .outs_valid(outs_valid_w[2]), .outs_ready(outs_ready), .outs_last(outs_last_w[2]));
    handshake_constant_seq #(.DATA_WIDTH(5), .DEPTH(3), .VALUES({5'd31, 5'd20, 5'd7}), .MODE(0)) dut3 (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready_w[3]),
        .outs(outs_w[3]), .outs_valid(outs_valid_w[3]), .outs_ready(outs_ready), .outs_last(outs_last_w[3]));

    // Hand-computed streams for nine back-to-back tokens after reset.
    localparam int EV [4][9] = '{'{14, 1, 9, 3, 14, 1, 9, 3, 14},
                                 '{14, 1, 9, 3, 3, 3, 3, 3, 3},
                                 '{14, 14, 14, 14, 14, 14, 14, 14, 14},
                                 '{7, 20, 31, 7, 20, 31, 7, 20, 31}};
    localparam int EL [4][9] = '{'{0, 0, 0, 1, 0, 0, 0, 1, 0},
                                 '{0, 0, 0, 1, 1, 1, 1, 1, 1},
                                 '{1, 1, 1, 1, 1, 1, 1, 1, 1},
                                 '{0, 0, 1, 0, 0, 1, 0, 0, 1}};

    int checks = 0;
    int errors = 0;

    // Reference: the k-th token since reset carries a value fixed by the table rule.
    function automatic logic [4:0] tbl4(input int j);
        case (j)
            0:       return 5'd14;
            1:       return 5'd1;
            2:       return 5'd9;
            default: return 5'd3;
        endcase
    endfunction

    function automatic logic [4:0] tbl3(input int j);
        case (j)
            0:       return 5'd7;
            1:       return 5'd20;
            default: return 5'd31;
        endcase
    endfunction

    function automatic logic [4:0] ref_val(input int inst, input int k);
        case (inst)
            0:       return tbl4(k % 4);
            1:       return tbl4((k < 3) ? k : 3);
            2:       return 5'd14;
            default: return tbl3(k % 3);
        endcase
    endfunction

    function automatic logic ref_last(input int inst, input int k);
        case (inst)
            0:       return (k % 4) == 3;
            1:       return k >= 3;
            2:       return 1'b1;
            default: return (k % 3) == 2;
        endcase
    endfunction

    bit         m_full [4];
    logic [4:0] m_val  [4];
    bit         m_last [4];
    int         m_k    [4];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m_full[i] <= 1'b0;
                m_k[i]    <= 0;
            end else if (ctrl_valid && (!m_full[i] || outs_ready)) begin
                m_val[i]  <= ref_val(i, m_k[i]);
                m_last[i] <= ref_last(i, m_k[i]);
                m_full[i] <= 1'b1;
                m_k[i]    <= m_k[i] + 1;
            end else if (outs_ready) begin
                m_full[i] <= 1'b0;
            end
        end
    end

    // Record every token handed to the consumer, plus handshake counts.
    logic [5:0] tr [4][2048];
    int tr_n    [4];
    int dut_in  [4];
    int dut_out [4];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (outs_valid_w[i] && outs_ready) begin
                if (tr_n[i] < 2048) begin
                    tr[i][tr_n[i]] <= {outs_last_w[i], outs_w[i]};
                    tr_n[i]        <= tr_n[i] + 1;
                end
                dut_out[i] <= dut_out[i] + 1;
            end
            if (ctrl_valid && ctrl_ready_w[i]) begin
                dut_in[i] <= dut_in[i] + 1;
            end
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0d expected %0d at %0t", nm, inst, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit v, input bit r);
        @(posedge clk);
        #2;
        ctrl_valid = v;
        outs_ready = r;
    endtask

    int         b    [4];
    int         in0  [4];
    int         out0 [4];
    logic [5:0] e;

    initial begin
        fork
            forever begin
                @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    chk("ctrl_ready", i, 32'(ctrl_ready_w[i]), 32'(!m_full[i] || outs_ready));
                    chk("outs_valid", i, 32'(outs_valid_w[i]), 32'(m_full[i]));
                    if (m_full[i]) begin
                        chk("outs", i, 32'(outs_w[i]), 32'(m_val[i]));
                        chk("outs_last", i, 32'(outs_last_w[i]), 32'(m_last[i]));
                    end
                end
            end
        join_none

        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_valid", i, 32'(outs_valid_w[i]), 0);
            chk("rst_outs", i, 32'(outs_w[i]), 0);
            chk("rst_last", i, 32'(outs_last_w[i]), 0);
        end
        @(posedge clk);
        #3 rst = 1'b0;

        // Full-rate streaming.
        for (int i = 0; i < 4; i++) b[i] = tr_n[i];
        repeat (9) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("stream_count", i, 32'(tr_n[i] - b[i]), 9);
            for (int j = 0; j < 9; j++) begin
                e = tr[i][b[i] + j];
                chk("stream_val", i, 32'(e[4:0]), 32'(EV[i][j]));
                chk("stream_last", i, 32'(e[5]), 32'(EL[i][j]));
            end
        end

        // Asynchronous reset with a token sitting in the slot.
        cyc(1'b1, 1'b0);
        @(posedge clk);
        #3;
        for (int i = 0; i < 4; i++) chk("pend_valid", i, 32'(outs_valid_w[i]), 1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("async_valid", i, 32'(outs_valid_w[i]), 0);
            chk("async_outs", i, 32'(outs_w[i]), 0);
            chk("async_last", i, 32'(outs_last_w[i]), 0);
        end
        ctrl_valid = 1'b0;
        outs_ready = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;

        // Backpressure: first token held for five cycles, then release.
        for (int i = 0; i < 4; i++) b[i] = tr_n[i];
        cyc(1'b1, 1'b1);
        repeat (5) begin
            cyc(1'b1, 1'b0);
            @(negedge clk);
            chk("bp_outs", 0, 32'(outs_w[0]), 14);
            chk("bp_valid", 0, 32'(outs_valid_w[0]), 1);
            chk("bp_ready", 0, 32'(ctrl_ready_w[0]), 0);
        end
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_count", i, 32'(tr_n[i] - b[i]), 2);
            for (int j = 0; j < 2; j++) begin
                e = tr[i][b[i] + j];
                chk("bp_val", i, 32'(e[4:0]), 32'(EV[i][j]));
            end
        end

        // Random valid/ready; the per-cycle compare carries the ordering check.
        for (int i = 0; i < 4; i++) begin
            in0[i]  = dut_in[i];
            out0[i] = dut_out[i];
        end
        repeat (1000) cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        repeat (3) cyc(1'b0, 1'b1);
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rand_balance", i, 32'(dut_out[i] - out0[i]), 32'(dut_in[i] - in0[i]));
            chk("rand_drained", i, 32'(outs_valid_w[i]), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
